// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU control and RV32M sequencer.
// ALU operation codes, M-extension funct3 ops, sequencer states, ALUOp encodings.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00001,
    ALU_AND  = 5'b00010,
    ALU_OR   = 5'b00011,
    ALU_SLL  = 5'b00100,
    ALU_SLT  = 5'b00101,
    ALU_SRL  = 5'b00110,
    ALU_SRA  = 5'b00111,
    ALU_XOR  = 5'b01001,
    ALU_SLTU = 5'b01010,
    ALU_MD   = 5'b01111
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_DONE
  } md_state_t;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_OP     = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [2:0] DTYPE_WORD = 3'b010;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied in DONE.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output md_state_t       state,
  output logic [XLEN-1:0] md_result,
  output logic            out_valid
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  md_state_t         state_q, state_d;
  md_op_t            op_in, op_q;
  logic              is_mul, a_signed, b_signed, sa, sb;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b, mag_b, res_q, res_d;
  logic              neg_q, neg_r;
  logic [2*XLEN-1:0] acc, prod;
  logic [CW-1:0]     cnt;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [XLEN-1:0]   div_rem;

  assign state = state_q;

  always_comb begin
    op_in    = md_op_t'(funct3);
    is_mul   = ~funct3[2];
    a_signed = op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_signed = op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    sa       = a_signed & src_a[XLEN-1];
    sb       = b_signed & src_b[XLEN-1];
    abs_a    = sa ? -src_a : src_a;
    abs_b    = sb ? -src_b : src_b;
    div_zero = ~is_mul & (src_b == '0);
    div_ovf  = ~is_mul & b_signed & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (src_b == '1);
  end

  // acc holds {high, low}: product for multiply, {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_b};
    div_rem   = div_trial[XLEN] ? acc[2*XLEN-2:XLEN-1] : div_trial[XLEN-1:0];
    prod      = neg_q ? -acc : acc;
    case (op_q)
      MD_MUL:                       res_d = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_d = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              res_d = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:                      res_d = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = (div_zero | div_ovf) ? ST_DONE : (is_mul ? ST_MUL : ST_DIV);
        ST_MUL:  if (cnt == LAST) state_d = ST_DONE;
        ST_DIV:  if (cnt == LAST) state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= MD_MUL;
      mag_b <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start && !flush) begin
          op_q  <= op_in;
          cnt   <= '0;
          mag_b <= abs_b;
          // Special cases are stored already in final form, so no sign fix-up.
          if (div_zero) begin
            acc   <= {src_a, {XLEN{1'b1}}};
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else if (div_ovf) begin
            acc   <= {{XLEN{1'b0}}, src_a};
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else begin
            acc   <= {{XLEN{1'b0}}, abs_a};
            neg_q <= sa ^ sb;
            neg_r <= sa;
          end
        end
        ST_MUL: begin
          acc <= {mul_sum, acc[XLEN-1:1]};
          cnt <= cnt + CW'(1);
        end
        ST_DIV: begin
          acc <= {div_rem, acc[XLEN-2:0], ~div_trial[XLEN]};
          cnt <= cnt + CW'(1);
        end
        default: if (!flush) res_q <= res_d;
      endcase
    end
  end

  assign md_result = (state_q == ST_DONE) ? res_d : res_q;
  assign out_valid = (state_q == ST_DONE) & ~flush;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// Execute-stage ALU control: decodes ALUOp/funct3/funct7 into an ALU code and
// load/store type, and steers RV32M ops to the iterative sequencer.
module alu_ctrl_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            op5,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            flush,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [4:0]      alu_control,
  output logic [2:0]      data_type,
  output logic            md_sel,
  output logic [XLEN-1:0] md_result,
  output logic            out_valid,
  output logic            in_ready,
  output logic            stall
);

  alu_ctrl_t ctrl;
  md_state_t md_state;
  logic      m_op, accept;

  assign m_op = in_valid & (alu_op == ALUOP_OP) & op5 & funct7_0;

  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_BRANCH: case (funct3)
        3'b100, 3'b101: ctrl = ALU_SLT;
        3'b110, 3'b111: ctrl = ALU_SLTU;
        default:        ctrl = ALU_SUB;
      endcase
      ALUOP_OP: case (funct3)
        3'b000:  ctrl = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  ctrl = ALU_SLL;
        3'b010:  ctrl = ALU_SLT;
        3'b011:  ctrl = ALU_SLTU;
        3'b100:  ctrl = ALU_XOR;
        3'b101:  ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  ctrl = ALU_OR;
        default: ctrl = ALU_AND;
      endcase
      default: ctrl = ALU_ADD;
    endcase
    if (m_op) ctrl = ALU_MD;
  end

  assign alu_control = ctrl;
  assign data_type   = (alu_op == ALUOP_LDST) ? funct3 : DTYPE_WORD;
  assign md_sel      = m_op;

  // Handshake: an M-op is taken when m_op & in_ready & ~flush in one cycle;
  // stall holds the pipeline until DONE, where out_valid pulses for one cycle.
  assign in_ready = (md_state == ST_IDLE);
  assign accept   = m_op & in_ready & ~flush;
  assign stall    = m_op & (md_state != ST_DONE);

  muldiv_seq #(.XLEN(XLEN)) u_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .flush     (flush),
    .funct3    (funct3),
    .src_a     (src_a),
    .src_b     (src_b),
    .state     (md_state),
    .md_result (md_result),
    .out_valid (out_valid)
  );

endmodule

// File: doc/alu_ctrl_muldiv.md
# alu_ctrl_muldiv

Execute-stage ALU control for the RISC-V core: decodes ALUOp/funct3/funct7 into a widened ALU control code and load/store data type, and adds RV32M support through an iterative multiply/divide sequencer that stalls the pipeline while it runs. It sits between the main decoder and the ALU/result mux. It supersedes the combinational ALU decoder. It corrects add/sub selection for I-type instructions and separates SRL from SRA.

## Interface
- XLEN, 32: operand and result width (any even value ≥ 8)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage holds a valid instruction
- alu_op  in  2  00 load/store, 01 branch, 10 op/op-imm
- funct3  in  3  instruction funct3
- op5  in  1  opcode bit 5 (1 = R-type)
- funct7_5  in  1  instruction bit 30
- funct7_0  in  1  instruction bit 25 (M-extension marker)
- flush  in  1  kill the in-flight instruction
- src_a, src_b  in  XLEN  operands
- alu_control  out  5  ALU operation code
- data_type  out  3  load/store size/sign (equals funct3 when alu_op=00, else 010)
- md_sel  out  1  result mux selects md_result
- md_result  out  XLEN  multiply/divide result
- out_valid  out  1  md_result valid (one-cycle pulse)
- in_ready  out  1  sequencer idle
- stall  out  1  hold the pipeline

## Operation
- Codes: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SLT, 00110 SRL, 00111 SRA, 01001 XOR, 01010 SLTU, 01111 MD.
- alu_op=00: ADD.
- alu_op=01, by funct3:
  - 000/001: SUB.
  - 100/101: SLT.
  - 110/111: SLTU.
  - Others: SUB.
- alu_op=10, by funct3:
  - 000: SUB only if op5 & funct7_5, else ADD.
  - 101: SRA if funct7_5, else SRL.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
- alu_op=11: ADD.
- M-op = in_valid & alu_op=10 & op5 & funct7_0. For an M-op: alu_control=MD, md_sel=1.
- M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states:
  - IDLE: an M-op is accepted when in_ready.
    - Divide by zero: go to DONE with quotient = all ones, remainder = src_a.
    - Signed DIV/REM of 0x8000_0000 by −1: go to DONE with quotient = src_a, remainder = 0.
    - Multiply: go to MUL.
    - Other divides: go to DIV.
  - MUL: XLEN shift-add iterations on operand magnitudes into a 2·XLEN accumulator.
  - DIV: XLEN restoring-division iterations on operand magnitudes.
  - DONE: apply sign correction.
    - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
    - Quotient sign = sign(a) XOR sign(b); remainder takes sign(a).
    - Then return to IDLE.
- Signedness: MULHSU treats src_a as signed and src_b as unsigned. DIVU, REMU and MULHU are fully unsigned.
- Operands are latched at acceptance. src_a/src_b may change afterwards without effect.

## Timing
- Decode outputs (alu_control, data_type, md_sel) are combinational, zero latency.
- Accept cycle = cycle 0:
  - MUL/DIV path: iterations occupy cycles 1..XLEN; DONE is cycle XLEN+1, with out_valid=1 and md_result valid.
  - Special-case divides: DONE is cycle 1.
- stall = M-op & state≠DONE. stall is high in the accept cycle and every busy cycle and low in DONE, so the pipeline advances at the end of DONE.
- in_ready = (state==IDLE). No acceptance occurs in DONE, so the same instruction is never re-issued.
- md_result holds its value until the next DONE.
- Flush: any state → IDLE next cycle, with no out_valid. Flush takes priority over acceptance in the same cycle.
- Reset:
  - state=IDLE, md_result=0, out_valid=0, internal accumulators/counter=0.
  - Reset mid-operation abandons the operation.
  - Combinational decode outputs follow their inputs during reset.
- The iteration counter is ⌈log2(XLEN+1)⌉ bits and stops exactly at XLEN.

## Structure
- Package alu_pkg holds:
  - alu_ctrl_t: 5-bit enum of the codes above.
  - md_op_t: M funct3 enum.
  - md_state_t: IDLE/MUL/DIV/DONE.
  - Constants for ALUOp encodings.
- Sub-module muldiv_seq, parametrised by XLEN, contains the FSM, operand/sign latches, counter and accumulator datapath.
- The top level holds only the combinational decode and the stall/md_sel glue.

## Test plan
- Decode sweep, all three cases below with M-op inactive:
  - addi with imm bit 30 set (alu_op=10, funct3=000, op5=0, funct7_5=1) → ADD.
  - R-type sub (op5=1, funct7_5=1) → SUB.
  - srai (funct3=101, funct7_5=1) → SRA.
- MUL path, XLEN=32:
  - MUL 7 × −3 → out_valid in cycle 33, md_result 0xFFFF_FFEB, stall high for cycles 0–32.
  - MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
- Signed divide: DIV −7/2 → 0xFFFF_FFFD; REM −7/2 → 0xFFFF_FFFF; both valid at cycle 33.
- Divide special cases, out_valid at cycle 1:
  - DIVU 5/0 → 0xFFFF_FFFF.
  - REM 5/0 → 5.
  - DIV 0x8000_0000/−1 → 0x8000_0000.
- Flush at cycle 10 of a DIV → IDLE at cycle 11, no out_valid. A new MUL 3×4 accepted at cycle 11 returns 12.
- Reset asserted mid-MUL → out_valid=0, in_ready=1 the next cycle. Reset value md_result=0. Repeat the MUL test with XLEN=8: 7×−3 → 0xEB at cycle 9.
